// File: rtl/bitrev_reorder_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bitrev_reorder_if
// Purpose : bundles the input and output streaming handshakes of the
//           bit-reversed-to-natural-order reorder buffer.
// Signals :
//   in_valid  - upstream has a sample on in_data
//   in_data   - WIDTH-bit packed complex sample (re in upper half)
//   in_ready  - reorder block accepts in_data this cycle
//   out_valid - out_data holds a valid sample
//   out_data  - WIDTH-bit sample, natural order
//   out_last  - marks the sample at natural index N-1
//   out_ready - downstream accepts out_data this cycle
// Modports :
//   master - the surrounding environment (drives in_*, takes out_*)
//   slave  - the reorder block itself
// -----------------------------------------------------------------------------
interface bitrev_reorder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/bitrev_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bitrev_reorder
// Purpose : converts frames of N = 2**N_LOG2 samples arriving in bit-reversed
//           order (DIF FFT output) into natural order. Two ping-pong banks of
//           N x WIDTH registers: one bank fills while the other drains, so a
//           continuous stream passes at one sample per cycle in each direction.
// Ports   :
//   clk  - single clock, all logic on its rising edge
//   rst  - synchronous, active-high reset (dominates every other input)
//   bus  - bitrev_reorder_if.slave
//          in_valid/in_data/in_ready   : input stream, bit-reversed order
//          out_valid/out_data/out_last/out_ready : output stream, natural
//          order, out_last with natural index N-1
// Parameters:
//   WIDTH  - sample width in bits (must match the interface WIDTH)
//   N_LOG2 - log2 of the frame length, 2..12
// -----------------------------------------------------------------------------
module bitrev_reorder #(
    parameter int WIDTH  = 32,
    parameter int N_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst,
    bitrev_reorder_if.slave bus
);
    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = {N_LOG2{1'b1}};

    // Per-bank lifecycle. Write-side events only happen in EMPTY/FILLING and
    // read-side events only in FULL/DRAINING, so one bank never sees both
    // kinds of event on the same edge.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    logic [N_LOG2-1:0] r_wcnt;
    logic [N_LOG2-1:0] r_rcnt;
    logic              r_wr_bank;
    logic              r_rd_bank;

    logic              r_out_valid;
    logic              r_out_last;
    logic [WIDTH-1:0]  r_out_data;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    bank_state_t       w_state   [2];
    logic [WIDTH-1:0]  w_rd_data [2];
    logic [N_LOG2-1:0] w_wr_addr;
    logic              w_in_ready;
    logic              w_wr_fire;
    logic              w_rd_avail;
    logic              w_rd_load;

    // Bit reversal of the write counter: pure wiring.
    for (genvar gi = 0; gi < N_LOG2; gi++) begin : g_bitrev
        assign w_wr_addr[gi] = r_wcnt[N_LOG2-1-gi];
    end

    // Writing is allowed only into a bank that is not holding a complete
    // frame; readiness comes straight from registered bank state.
    assign w_in_ready = (w_state[r_wr_bank] == BANK_EMPTY) ||
                        (w_state[r_wr_bank] == BANK_FILLING);
    assign w_wr_fire  = bus.in_valid && w_in_ready;

    // Reading is allowed only from a bank holding a complete frame. The
    // output register reloads whenever it is empty or being consumed.
    assign w_rd_avail = (w_state[r_rd_bank] == BANK_FULL) ||
                        (w_state[r_rd_bank] == BANK_DRAINING);
    assign w_rd_load  = w_rd_avail && (!r_out_valid || bus.out_ready);

    // -------------------------------------------------------------------------
    // Banks: storage plus lifecycle state
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);

        logic [WIDTH-1:0] r_mem [N];
        bank_state_t      r_state;
        logic             w_wr_hit;
        logic             w_rd_hit;

        assign w_wr_hit = w_wr_fire && (r_wr_bank == BANK_ID);
        assign w_rd_hit = w_rd_load && (r_rd_bank == BANK_ID);

        // Contents are intentionally not reset; bank state alone decides
        // whether the data is meaningful.
        always_ff @(posedge clk) begin
            if (w_wr_hit) begin
                r_mem[w_wr_addr] <= bus.in_data;
            end
        end

        // Asynchronous read at the natural-order index.
        assign w_rd_data[gi] = r_mem[r_rcnt];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= BANK_EMPTY;
            end else begin
                case (r_state)
                    BANK_EMPTY, BANK_FILLING: begin
                        if (w_wr_hit) begin
                            r_state <= (r_wcnt == LAST_IDX) ? BANK_FULL : BANK_FILLING;
                        end
                    end
                    BANK_FULL, BANK_DRAINING: begin
                        if (w_rd_hit) begin
                            r_state <= (r_rcnt == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
                        end
                    end
                    default: r_state <= BANK_EMPTY;
                endcase
            end
        end

        assign w_state[gi] = r_state;
    end

    // -------------------------------------------------------------------------
    // Write side: counter and bank pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt    <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            // Counter wraps to zero naturally after N-1.
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST_IDX) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read side: counter, bank pointer and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt      <= '0;
            r_rd_bank   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_rd_load) begin
                r_out_data  <= w_rd_data[r_rd_bank];
                r_out_last  <= (r_rcnt == LAST_IDX);
                r_out_valid <= 1'b1;
                r_rcnt      <= r_rcnt + 1'b1;
                if (r_rcnt == LAST_IDX) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (bus.out_ready) begin
                // Sample consumed with nothing behind it: go idle. Data is
                // left as is; only valid/last are meaningful here.
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_bitrev_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bitrev_reorder
// Directed checks of the bit-reversed to natural order reorder buffer on three
// instances: N=8 (basic, back-to-back, backpressure, mid-frame reset),
// N=16 (random handshake toggling over 100 frames) and N=256 (defaults).
// -----------------------------------------------------------------------------
module tb_bitrev_reorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitrev_reorder_if #(.WIDTH(16)) if3 ();
    bitrev_reorder_if #(.WIDTH(16)) if4 ();
    bitrev_reorder_if #(.WIDTH(32)) if8 ();

    bitrev_reorder #(.WIDTH(16), .N_LOG2(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    bitrev_reorder #(.WIDTH(16), .N_LOG2(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    bitrev_reorder u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-computed bit-reversal tables.
    int br3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int br4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if3.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        if8.in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rev8(input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7-i] = k[i];
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int cyc;

        if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        check_val("rst_in_ready",  32'(if3.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(if3.out_valid), 32'd0);
        check_val("rst_out_last",  32'(if3.out_last),  32'd0);
        check_val("rst_out_data",  32'(if3.out_data),  32'd0);
        check_val("rst8_in_ready", 32'(if8.in_ready),  32'd1);

        // ---------------- A: single frame, N=8 ----------------
        if3.out_ready = 1'b1;
        if3.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if3.in_data = 16'(br3[k]);
            check_val("A_in_ready", 32'(if3.in_ready), 32'd1);
            tick();
        end
        if3.in_valid = 1'b0;
        check_val("A_gap_valid", 32'(if3.out_valid), 32'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            check_val("A_valid", 32'(if3.out_valid), 32'd1);
            check_val("A_data",  32'(if3.out_data),  32'(j));
            check_val("A_last",  32'(if3.out_last),  32'(j == 7));
        end
        tick();
        check_val("A_end_valid", 32'(if3.out_valid), 32'd0);

        // ---------------- B: 4 back-to-back frames ----------------
        do_reset();
        if3.out_ready = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e <= 32) begin
                if3.in_valid = 1'b1;
                if3.in_data  = 16'(((e - 1) / 8) * 8 + br3[(e - 1) % 8]);
                check_val("B_in_ready", 32'(if3.in_ready), 32'd1);
            end else begin
                if3.in_valid = 1'b0;
            end
            tick();
            if (e >= 9) begin
                check_val("B_valid", 32'(if3.out_valid), 32'd1);
                check_val("B_data",  32'(if3.out_data),  32'(e - 9));
                check_val("B_last",  32'(if3.out_last),  32'(((e - 9) % 8) == 7));
            end else begin
                check_val("B_idle", 32'(if3.out_valid), 32'd0);
            end
        end
        tick();
        check_val("B_end_valid", 32'(if3.out_valid), 32'd0);

        // ---------------- C: backpressure from reset ----------------
        do_reset();
        if3.out_ready = 1'b0;
        if3.in_valid  = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if3.in_data = 16'(16'h40 + ((e - 1) / 8) * 8 + br3[(e - 1) % 8]);
            check_val("C_in_ready", 32'(if3.in_ready), 32'd1);
            tick();
        end
        check_val("C_full_ready", 32'(if3.in_ready),  32'd0);
        check_val("C_hold_valid", 32'(if3.out_valid), 32'd1);
        check_val("C_hold_data",  32'(if3.out_data),  32'h40);
        check_val("C_hold_last",  32'(if3.out_last),  32'd0);
        for (int h = 0; h < 3; h++) begin
            tick();
            check_val("C_stall_ready", 32'(if3.in_ready),  32'd0);
            check_val("C_stall_valid", 32'(if3.out_valid), 32'd1);
            check_val("C_stall_data",  32'(if3.out_data),  32'h40);
        end
        if3.in_valid  = 1'b0;
        if3.out_ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick();
            check_val("C_valid",    32'(if3.out_valid), 32'd1);
            check_val("C_data",     32'(if3.out_data),  32'(16'h40 + k));
            check_val("C_last",     32'(if3.out_last),  32'((k % 8) == 7));
            check_val("C_in_ready", 32'(if3.in_ready),  32'(k >= 7));
        end
        tick();
        check_val("C_end_valid", 32'(if3.out_valid), 32'd0);
        check_val("C_end_ready", 32'(if3.in_ready),  32'd1);

        // ---------------- D: reset mid-frame ----------------
        do_reset();
        if3.out_ready = 1'b1;
        if3.in_valid  = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            if3.in_data = 16'(16'h60 + ((e - 1) / 8) * 8 + br3[(e - 1) % 8]);
            tick();
        end
        check_val("D_pre_valid", 32'(if3.out_valid), 32'd1);
        check_val("D_pre_data",  32'(if3.out_data),  32'h64);
        // in_valid stays high through the reset edge: reset must win.
        if3.in_data = 16'h7777;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("D_rst_valid", 32'(if3.out_valid), 32'd0);
        check_val("D_rst_ready", 32'(if3.in_ready),  32'd1);
        check_val("D_rst_last",  32'(if3.out_last),  32'd0);
        check_val("D_rst_data",  32'(if3.out_data),  32'd0);
        for (int p = 0; p < 8; p++) begin
            if3.in_data = 16'(16'h80 + br3[p]);
            tick();
            check_val("D_wait_valid", 32'(if3.out_valid), 32'd0);
        end
        if3.in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            check_val("D_valid", 32'(if3.out_valid), 32'd1);
            check_val("D_data",  32'(if3.out_data),  32'(16'h80 + j));
            check_val("D_last",  32'(if3.out_last),  32'(j == 7));
        end
        tick();
        check_val("D_end_valid", 32'(if3.out_valid), 32'd0);

        // ---------------- E: random handshakes, N=16, 100 frames ----------------
        do_reset();
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1600 && cyc < 20000) begin
            if4.in_valid  = (sent < 1600) && ($urandom_range(0, 1) == 1);
            if4.in_data   = 16'((sent / 16) * 16 + br4[sent % 16]);
            if4.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (if4.in_valid && if4.in_ready) sent++;
            if (if4.out_valid && if4.out_ready) begin
                check_val("E_data", 32'(if4.out_data), 32'(recv));
                check_val("E_last", 32'(if4.out_last), 32'((recv % 16) == 15));
                recv++;
            end
            tick();
            cyc++;
        end
        check_val("E_count", 32'(recv), 32'd1600);
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        tick();
        tick();
        check_val("E_idle_valid", 32'(if4.out_valid), 32'd0);

        // ---------------- F: default parameters, N=256 ----------------
        do_reset();
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            if8.in_data = rev8(k);
            tick();
        end
        if8.in_valid = 1'b0;
        recv = 0;
        cyc  = 0;
        while (recv < 256 && cyc < 1000) begin
            @(negedge clk);
            if (if8.out_valid) begin
                check_val("F_data", if8.out_data, 32'(recv));
                check_val("F_last", 32'(if8.out_last), 32'(recv == 255));
                recv++;
            end
            tick();
            cyc++;
        end
        check_val("F_count", 32'(recv), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
